// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the MIPS core's multiply/divide unit.
package mips_pkg;
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: EX-stage multiply/divide unit owning HI/LO, with emulated
// multi-cycle latency; results are computed at issue and committed after N cycles.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    md_state_e      r_state;
    logic [CW-1:0]  r_cnt;
    logic [63:0]    r_pend;
    logic           r_dz;

    logic               w_b_zero;
    logic signed [32:0] w_sa;
    logic signed [32:0] w_sb;
    logic [31:0]        w_sq;
    logic [31:0]        w_sr;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic [63:0]        w_smul;
    logic [63:0]        w_umul;
    logic [63:0]        w_result;

    assign w_b_zero = (b == 32'd0);
    // 33-bit signed operands make 0x80000000 / -1 yield +2^31, which wraps to 0x80000000
    assign w_sa = {a[31], a};
    assign w_sb = {b[31], b};
    assign w_sq = w_b_zero ? 32'd0 : 32'(w_sa / w_sb);
    assign w_sr = w_b_zero ? 32'd0 : 32'(w_sa % w_sb);
    assign w_uq = w_b_zero ? 32'd0 : a / b;
    assign w_ur = w_b_zero ? 32'd0 : a % b;
    assign w_smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_umul = {32'd0, a} * {32'd0, b};

    always_comb begin
        w_result = (op == MD_MULT)  ? w_smul :
                   (op == MD_MULTU) ? w_umul :
                   (op == MD_DIV)   ? {w_sr, w_sq} :
                                      {w_ur, w_uq};
    end

    assign stall_req = busy | (start & ~op[2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_dz    <= 1'b0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            r_pend  <= w_result;
                            r_dz    <= op[1] & w_b_zero;
                            r_cnt   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            busy    <= 1'b1;
                            r_state <= MD_RUN;
                        end else if (op == MD_MTHI) begin
                            hi <= a;
                        end else if (op == MD_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                MD_RUN: begin
                    if (r_cnt == CW'(1)) begin
                        if (!r_dz) {hi, lo} <= r_pend;
                        busy    <= 1'b0;
                        r_state <= MD_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven directed checks of mult_div_unit plus
// hand sequences for async reset mid-run and start while busy.
module tb_mult_div_unit;
    import mips_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    vec_t vecs[14];

    mult_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int n;
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        #1 chk({nm, " stall_issue"}, 64'(stall_req), 64'(!v.op[2]));
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            chk({nm, " hi_hold"}, 64'(hi), 64'(m_hi));
            chk({nm, " lo_hold"}, 64'(lo), 64'(m_lo));
            chk({nm, " stall_busy"}, 64'(stall_req), 64'd1);
            @(posedge clk);
            #1 n++;
        end
        chk({nm, " busy_cycles"}, 64'(n), 64'(v.cyc));
        chk({nm, " hi"}, 64'(hi), 64'(v.hi));
        chk({nm, " lo"}, 64'(lo), 64'(v.lo));
        chk({nm, " stall_after"}, 64'(stall_req), 64'd0);
        m_hi = v.hi;
        m_lo = v.lo;
    endtask

    initial begin
        int n;
        vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{MD_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
        vecs[4]  = '{MD_MTHI,  32'h11,       32'd0,        32'h00000011, 32'h7FFFFFFC, 0};
        vecs[5]  = '{MD_MTLO,  32'h22,       32'd0,        32'h00000011, 32'h00000022, 0};
        vecs[6]  = '{MD_DIV,   32'd5,        32'd0,        32'h00000011, 32'h00000022, 10};
        vecs[7]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[8]  = '{3'd6,     32'h1234,     32'h5678,     32'h00000000, 32'h80000000, 0};
        vecs[9]  = '{3'd7,     32'h1234,     32'h5678,     32'h00000000, 32'h80000000, 0};
        vecs[10] = '{MD_MULT,  32'd100000,   32'd100000,   32'h00000002, 32'h540BE400, 5};
        vecs[11] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[12] = '{MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        vecs[13] = '{MD_MULT,  32'd0,        32'h1234,     32'h00000000, 32'h00000000, 5};

        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset stall", 64'(stall_req), 64'd0);

        run_op('{MD_MTHI, 32'h55, 32'd0, 32'h55, 32'h0, 0}, "pre_mthi");
        @(negedge clk);
        start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_mid busy", 64'(busy), 64'd0);
        chk("rst_mid hi", 64'(hi), 64'd0);
        chk("rst_mid lo", 64'(lo), 64'd0);
        @(negedge clk) reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_after busy", 64'(busy), 64'd0);
        chk("rst_after hi", 64'(hi), 64'd0);
        chk("rst_after lo", 64'(lo), 64'd0);
        m_hi = '0;
        m_lo = '0;

        for (int i = 0; i < 14; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        @(negedge clk);
        start = 1'b1; op = MD_MULT; a = 32'd6; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = MD_MTHI; a = 32'hDEAD;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_ign hi_hold", 64'(hi), 64'd0);
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk("busy_ign remaining", 64'(n), 64'd2);
        chk("busy_ign hi", 64'(hi), 64'd0);
        chk("busy_ign lo", 64'(lo), 64'd42);
        m_hi = 32'd0;
        m_lo = 32'd42;
        run_op('{MD_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 5}, "next_mult");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
